// File: rtl/uart_rx_oversampled.sv
// UART receiver: 2-flop synchroniser, centre sampling on an oversampling tick,
// valid/ready holding register with frame, parity and overrun flags.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 tick_os,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic HAS_PAR = (PARITY_EN != 0);
  localparam logic ODD_PAR = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state, stateNext;
  logic                 rxMeta, rxs;
  logic [CW-1:0]        cnt, cntNext;
  logic [BW-1:0]        bitIdx, bitNext;
  logic [DATA_BITS-1:0] shReg, shNext;
  logic                 parErr, parNext;
  logic                 done;
  logic                 load, accept;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rxd;
      rxs    <= rxMeta;
    end
  end

  // Frame FSM and datapath registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shReg  <= '0;
      parErr <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      bitIdx <= bitNext;
      shReg  <= shNext;
      parErr <= parNext;
    end
  end

  // Next-state: everything advances only on tick_os; done marks the stop-bit centre
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    bitNext   = bitIdx;
    shNext    = shReg;
    parNext   = parErr;
    done      = 1'b0;
    if (tick_os) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            stateNext = START;
            cntNext   = '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            // a high line at the start-bit centre was only a glitch
            stateNext = rxs ? IDLE : DATA;
            cntNext   = '0;
            bitNext   = '0;
            parNext   = 1'b0;
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            shNext  = {rxs, shReg[DATA_BITS-1:1]};
            cntNext = '0;
            if (bitIdx == BIT_LAST)
              stateNext = HAS_PAR ? PARITY : STOP;
            else
              bitNext = bitIdx + BW'(1);
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cnt == CNT_END) begin
            parNext   = ((^shReg) ^ rxs) != ODD_PAR;
            cntNext   = '0;
            stateNext = STOP;
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_END) begin
            done      = 1'b1;
            cntNext   = '0;
            // a low stop bit may be a break; hold off re-arming until the line rises
            stateNext = rxs ? IDLE : BRK;
          end else begin
            cntNext = cnt + CW'(1);
          end
        end
        BRK: begin
          if (rxs) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign accept = rx_valid && rx_ready;
  // a drain in the same cycle frees the holding register for the new byte
  assign load   = done && (!rx_valid || rx_ready);
  assign busy   = (state != IDLE);

  // Holding register with valid/ready handshake and one-cycle overrun pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      if (load) begin
        rx_data       <= shReg;
        rx_frame_err  <= ~rxs;
        rx_parity_err <= parErr;
        rx_valid      <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
